// File: rtl/sound_pkg.sv
// Shared types, sizing constants and the per-event note table for the sound event sequencer.
package sound_pkg;

  localparam int NUM_EVENTS = 4;
  localparam int NOTES      = 4;
  localparam int FREQ_W     = 4;
  localparam int DUR_W      = 6;
  localparam int GAP_TICKS  = 2;

  localparam int EV_W  = $clog2(NUM_EVENTS);
  localparam int IDX_W = $clog2(NOTES);
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  localparam int EV_WIN       = 0;
  localparam int EV_LOSE      = 1;
  localparam int EV_COLLISION = 2;
  localparam int EV_AUX       = 3;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [DUR_W-1:0]  dur;
  } note_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // A zero duration terminates a pattern; a zero first note marks the event as silent.
  localparam note_t PATTERNS [NUM_EVENTS][NOTES] = '{
    '{'{4'd9, 6'd4}, '{4'd11, 6'd4}, '{4'd13, 6'd4}, '{4'd15, 6'd4}},
    '{'{4'd3, 6'd8}, '{4'd1,  6'd8}, '{4'd0,  6'd0}, '{4'd0,  6'd0}},
    '{'{4'd5, 6'd2}, '{4'd0,  6'd0}, '{4'd0,  6'd0}, '{4'd0,  6'd0}},
    '{'{4'd7, 6'd3}, '{4'd0,  6'd0}, '{4'd0,  6'd0}, '{4'd0,  6'd0}}
  };

endpackage

// File: rtl/sound_priority_encoder.sv
// Lowest-set-index encoder with a valid flag; index 0 has the highest priority.
module sound_priority_encoder #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  output logic         vld_o,
  output logic [W-1:0] idx_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    vld_o = |req_i;
    idx_o = {W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = W'(i);
      end
    end
  end

endmodule

// File: rtl/sound_event_sequencer.sv
// Plays a multi-note pattern per event pulse, with fixed-priority preemption and one-deep pending per channel.
module sound_event_sequencer
  import sound_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  tick,
  input  logic [NUM_EVENTS-1:0] event_pulse,
  input  logic                  mute,
  output logic                  enable_sound,
  output logic [FREQ_W-1:0]     freq,
  output logic [EV_W-1:0]       active_event,
  output logic                  busy,
  output logic [NUM_EVENTS-1:0] pending
);

  state_t                state_q, state_d;
  logic [EV_W-1:0]       ev_q, ev_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DUR_W-1:0]      cnt_q, cnt_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [NUM_EVENTS-1:0] pend_q, pend_d;
  logic                  en_q, en_d;
  logic [FREQ_W-1:0]     freq_q, freq_d;
  logic                  busy_q, busy_d;

  logic [NUM_EVENTS-1:0] playable_s;
  logic [NUM_EVENTS-1:0] req_s;
  logic                  req_vld_s, pend_vld_s;
  logic [EV_W-1:0]       req_idx_s, pend_idx_s;
  logic [IDX_W-1:0]      idx_nxt_s;
  logic                  last_s;
  note_t                 cur_note_s;

  // Events whose first note is empty are dropped before arbitration.
  always_comb begin
    playable_s = {NUM_EVENTS{1'b0}};
    for (int e = 0; e < NUM_EVENTS; e++) begin
      playable_s[e] = (PATTERNS[e][0].dur != {DUR_W{1'b0}});
    end
    req_s = event_pulse & playable_s;
  end

  sound_priority_encoder #(.N(NUM_EVENTS), .W(EV_W)) u_req_enc (
    .req_i (req_s),
    .vld_o (req_vld_s),
    .idx_o (req_idx_s)
  );

  sound_priority_encoder #(.N(NUM_EVENTS), .W(EV_W)) u_pend_enc (
    .req_i (pend_q),
    .vld_o (pend_vld_s),
    .idx_o (pend_idx_s)
  );

  assign cur_note_s = PATTERNS[ev_q][idx_q];
  assign idx_nxt_s  = idx_q + IDX_W'(1);
  assign last_s     = (idx_q == IDX_W'(NOTES - 1)) ||
                      (PATTERNS[ev_q][idx_nxt_s].dur == {DUR_W{1'b0}});

  // Tick-driven note/gap timing first, then event arbitration against the resulting state.
  always_comb begin
    state_d = state_q;
    ev_d    = ev_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    pend_d  = pend_q;

    case (state_q)
      S_PLAY: begin
        if (tick) begin
          if (cnt_q == cur_note_s.dur - DUR_W'(1)) begin
            cnt_d = {DUR_W{1'b0}};
            if (last_s) begin
              idx_d = {IDX_W{1'b0}};
              if (pend_vld_s) begin
                ev_d               = pend_idx_s;
                pend_d[pend_idx_s] = 1'b0;
              end else begin
                state_d = S_IDLE;
              end
            end else if (GAP_TICKS == 0) begin
              idx_d = idx_nxt_s;
            end else begin
              state_d = S_GAP;
              gap_d   = {GAP_W{1'b0}};
            end
          end else begin
            cnt_d = cnt_q + DUR_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_GAP: begin
        if (tick) begin
          if (gap_q == GAP_W'(GAP_TICKS - 1)) begin
            state_d = S_PLAY;
            idx_d   = idx_nxt_s;
            gap_d   = {GAP_W{1'b0}};
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end else begin
          gap_d = gap_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Higher or equal priority (re)starts at note 0; the displaced event is not pended.
    if (req_vld_s && ((state_d == S_IDLE) || (req_idx_s <= ev_d))) begin
      state_d      = S_PLAY;
      ev_d         = req_idx_s;
      idx_d        = {IDX_W{1'b0}};
      cnt_d        = {DUR_W{1'b0}};
      gap_d        = {GAP_W{1'b0}};
      pend_d[ev_d] = 1'b0;
    end else begin
      pend_d = pend_d;
    end

    for (int i = 0; i < NUM_EVENTS; i++) begin
      if ((state_d != S_IDLE) && (EV_W'(i) > ev_d)) begin
        pend_d[i] = pend_d[i] | req_s[i];
      end else begin
        pend_d[i] = pend_d[i];
      end
    end

    busy_d = (state_d != S_IDLE);
    en_d   = (state_d == S_PLAY) && !mute;
    case (state_d)
      S_PLAY:  freq_d = PATTERNS[ev_d][idx_d].freq;
      S_GAP:   freq_d = freq_q;
      default: freq_d = {FREQ_W{1'b0}};
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      ev_q    <= {EV_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      cnt_q   <= {DUR_W{1'b0}};
      gap_q   <= {GAP_W{1'b0}};
      pend_q  <= {NUM_EVENTS{1'b0}};
      en_q    <= 1'b0;
      freq_q  <= {FREQ_W{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ev_q    <= ev_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      freq_q  <= freq_d;
      busy_q  <= busy_d;
    end
  end

  assign enable_sound = en_q;
  assign freq         = freq_q;
  assign active_event = ev_q;
  assign busy         = busy_q;
  assign pending      = pend_q;

endmodule
